// File: rtl/plic_core.sv
// plic_core: PLIC register file, level-triggered gateway, claim/complete
// arbitration and registered per-context external interrupt lines.
module plic_core #(
    parameter int N_SRC  = 31,
    parameter int N_CTX  = 2,
    parameter int PRIO_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [25:0]      reg_addr,
    input  logic             reg_read,
    input  logic             reg_write,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    input  logic [N_SRC:0]   irq_src,
    output logic [N_CTX-1:0] eip
);

    localparam int ID_W = $clog2(N_SRC + 1);

    // Priority and threshold fields are WARL: only the low PRIO_W bits stick.
    function automatic logic [PRIO_W-1:0] warl_prio(input logic [31:0] d);
        return d[PRIO_W-1:0];
    endfunction

    logic [PRIO_W-1:0] prio   [1:N_SRC];
    logic [N_SRC:1]    enable [N_CTX];
    logic [PRIO_W-1:0] thresh [N_CTX];
    logic [N_SRC:1]    pending;
    logic [N_SRC:1]    inflight;
    logic [N_CTX-1:0]  eip_p0;
    logic [N_CTX-1:0]  eip_p1;

    logic [9:0]        prio_word;
    logic [4:0]        en_ctx;
    logic [8:0]        thr_ctx;
    logic              hit_prio;
    logic              hit_pend;
    logic              en_region;
    logic              thr_region;
    logic              claim_region;
    logic [N_CTX-1:0]  en_hit;
    logic [N_CTX-1:0]  thr_hit;
    logic [N_CTX-1:0]  claim_hit;

    logic [ID_W-1:0]   win_id [N_CTX];
    logic [ID_W-1:0]   claim_id;
    logic              claim_fire;
    logic [N_SRC:1]    claim_set;
    logic [N_SRC:1]    cmpl_clr;

    // Source 0 does not exist; its input bit is intentionally dropped.
    logic              unused_irq0;
    assign unused_irq0 = irq_src[0];

    assign prio_word    = reg_addr[11:2];
    assign en_ctx       = reg_addr[11:7];
    assign thr_ctx      = reg_addr[20:12];
    assign hit_prio     = (reg_addr[25:12] == 14'd0) && (reg_addr[1:0] == 2'd0) &&
                          (prio_word >= 10'd1) && (prio_word <= 10'(N_SRC));
    assign hit_pend     = (reg_addr == 26'h000_1000);
    assign en_region    = (reg_addr[25:12] == 14'h0002) && (reg_addr[6:0] == 7'd0);
    assign thr_region   = (reg_addr[25:21] == 5'h01) && (reg_addr[11:0] == 12'h000);
    assign claim_region = (reg_addr[25:21] == 5'h01) && (reg_addr[11:0] == 12'h004);

    // Per-context address match for the enable, threshold and claim windows.
    always_comb begin
        en_hit    = '0;
        thr_hit   = '0;
        claim_hit = '0;
        for (int c = 0; c < N_CTX; c++) begin
            en_hit[c]    = en_region    && (en_ctx  == 5'(c));
            thr_hit[c]   = thr_region   && (thr_ctx == 9'(c));
            claim_hit[c] = claim_region && (thr_ctx == 9'(c));
        end
    end

    // Claim winner per context: highest priority, strict compare keeps the lowest ID on ties.
    always_comb begin
        logic [PRIO_W-1:0] bp;
        logic [ID_W-1:0]   bid;
        bp  = '0;
        bid = '0;
        for (int c = 0; c < N_CTX; c++) begin
            bp  = '0;
            bid = '0;
            for (int i = 1; i <= N_SRC; i++) begin
                if (pending[i] && enable[c][i] && (prio[i] > bp)) begin
                    bp  = prio[i];
                    bid = ID_W'(i);
                end
            end
            win_id[c] = bid;
        end
    end

    // Next-cycle interrupt line: any pending, enabled source above the context threshold.
    always_comb begin
        eip_p0 = '0;
        for (int c = 0; c < N_CTX; c++) begin
            for (int i = 1; i <= N_SRC; i++) begin
                if (pending[i] && enable[c][i] && (prio[i] > thresh[c])) begin
                    eip_p0[c] = 1'b1;
                end
            end
        end
    end

    // Claim and complete side-effect vectors for the gateway flops.
    always_comb begin
        claim_id  = '0;
        claim_set = '0;
        cmpl_clr  = '0;
        for (int c = 0; c < N_CTX; c++) begin
            if (claim_hit[c]) begin
                claim_id = win_id[c];
            end
        end
        claim_fire = reg_read && (claim_id != '0);
        for (int i = 1; i <= N_SRC; i++) begin
            claim_set[i] = claim_fire && (claim_id == ID_W'(i));
            for (int c = 0; c < N_CTX; c++) begin
                if (reg_write && claim_hit[c] && (reg_wdata == 32'(i)) && enable[c][i]) begin
                    cmpl_clr[i] = 1'b1;
                end
            end
        end
    end

    // Gateway: a claim wins over re-pend; inflight blocks re-pend until completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            inflight <= '0;
        end else begin
            for (int i = 1; i <= N_SRC; i++) begin
                if (claim_set[i]) begin
                    pending[i]  <= 1'b0;
                    inflight[i] <= 1'b1;
                end else begin
                    if (irq_src[i] && !pending[i] && !inflight[i]) begin
                        pending[i] <= 1'b1;
                    end
                    if (cmpl_clr[i]) begin
                        inflight[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Software-visible configuration: priority, enable and threshold writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= N_SRC; i++) begin
                prio[i] <= '0;
            end
            for (int c = 0; c < N_CTX; c++) begin
                enable[c] <= '0;
                thresh[c] <= '0;
            end
        end else if (reg_write) begin
            for (int i = 1; i <= N_SRC; i++) begin
                if (hit_prio && (prio_word == 10'(i))) begin
                    prio[i] <= warl_prio(reg_wdata);
                end
            end
            for (int c = 0; c < N_CTX; c++) begin
                if (en_hit[c]) begin
                    enable[c] <= reg_wdata[N_SRC:1];
                end
                if (thr_hit[c]) begin
                    thresh[c] <= warl_prio(reg_wdata);
                end
            end
        end
    end

    // Registered interrupt lines toward the harts.
    always_ff @(posedge clk) begin
        if (rst) begin
            eip_p1 <= '0;
        end else begin
            eip_p1 <= eip_p0;
        end
    end

    assign eip = eip_p1;

    // Zero-wait read mux; unmapped offsets and reserved bits return 0.
    always_comb begin
        reg_rdata = '0;
        if (hit_prio) begin
            for (int i = 1; i <= N_SRC; i++) begin
                if (prio_word == 10'(i)) begin
                    reg_rdata = 32'(prio[i]);
                end
            end
        end
        if (hit_pend) begin
            reg_rdata = 32'({pending, 1'b0});
        end
        for (int c = 0; c < N_CTX; c++) begin
            if (en_hit[c]) begin
                reg_rdata = 32'({enable[c], 1'b0});
            end
            if (thr_hit[c]) begin
                reg_rdata = 32'(thresh[c]);
            end
            if (claim_hit[c]) begin
                reg_rdata = 32'(win_id[c]);
            end
        end
    end

endmodule

// File: tb/tb_plic_core.sv
// tb_plic_core: directed scenarios plus randomized traffic against a
// behavioural PLIC model, compared every cycle on the falling edge.
module tb_plic_core;

    localparam int N_SRC  = 31;
    localparam int N_CTX  = 2;
    localparam int PRIO_W = 3;
    localparam logic [31:0] SRC_MASK  = 32'(((64'd1 << N_SRC) - 64'd1) << 1);
    localparam logic [31:0] PRIO_MASK = 32'((1 << PRIO_W) - 1);

    logic             clk;
    logic             rst;
    logic [25:0]      reg_addr;
    logic             reg_read;
    logic             reg_write;
    logic [31:0]      reg_wdata;
    logic [31:0]      reg_rdata;
    logic [N_SRC:0]   irq_src;
    logic [N_CTX-1:0] eip;

    plic_core #(.N_SRC(N_SRC), .N_CTX(N_CTX), .PRIO_W(PRIO_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_addr  (reg_addr),
        .reg_read  (reg_read),
        .reg_write (reg_write),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq_src   (irq_src),
        .eip       (eip)
    );

    // Behavioural model state
    int               m_prio [0:N_SRC];
    logic [31:0]      m_en   [N_CTX];
    int               m_thr  [N_CTX];
    logic [31:0]      m_pend;
    logic [31:0]      m_infl;
    logic [N_CTX-1:0] m_eip;
    bit               chk_en;

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Address classification straight from the register map arithmetic.
    function automatic int prio_idx(input logic [25:0] a);
        int ai;
        ai = int'(a);
        if (ai < 'h1000 && ai % 4 == 0 && ai / 4 >= 1 && ai / 4 <= N_SRC) return ai / 4;
        return 0;
    endfunction

    function automatic int en_ctx(input logic [25:0] a);
        int ai;
        ai = int'(a);
        if (ai >= 'h2000 && (ai - 'h2000) % 'h80 == 0 && (ai - 'h2000) / 'h80 < N_CTX)
            return (ai - 'h2000) / 'h80;
        return -1;
    endfunction

    function automatic int ctx_reg(input logic [25:0] a, input int off);
        int ai;
        ai = int'(a);
        if (ai >= 'h200000 && (ai - 'h200000) % 'h1000 == off && (ai - 'h200000) / 'h1000 < N_CTX)
            return (ai - 'h200000) / 'h1000;
        return -1;
    endfunction

    // Scan priority levels from the top; the first source found at a level is the lowest ID.
    function automatic int winner(input int c);
        int w;
        w = 0;
        for (int p = (1 << PRIO_W) - 1; p >= 1; p--) begin
            for (int i = 1; i <= N_SRC; i++) begin
                if (w == 0 && m_pend[i] && m_en[c][i] && m_prio[i] == p) w = i;
            end
        end
        return w;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [25:0] a);
        int k;
        k = prio_idx(a);
        if (k != 0) return 32'(m_prio[k]);
        if (a == 26'h1000) return m_pend;
        k = en_ctx(a);
        if (k >= 0) return m_en[k];
        k = ctx_reg(a, 0);
        if (k >= 0) return 32'(m_thr[k]);
        k = ctx_reg(a, 4);
        if (k >= 0) return 32'(winner(k));
        return 32'h0;
    endfunction

    task automatic model_step();
        logic [31:0]      pend_n;
        logic [31:0]      infl_n;
        logic [N_CTX-1:0] eip_n;
        int               w;
        int               cc;
        int               k;
        int               id;
        if (rst) begin
            for (int i = 0; i <= N_SRC; i++) m_prio[i] = 0;
            for (int c = 0; c < N_CTX; c++) begin
                m_en[c]  = 32'h0;
                m_thr[c] = 0;
            end
            m_pend = 32'h0;
            m_infl = 32'h0;
            m_eip  = '0;
        end else begin
            eip_n = '0;
            for (int c = 0; c < N_CTX; c++)
                for (int i = 1; i <= N_SRC; i++)
                    if (m_pend[i] && m_en[c][i] && m_prio[i] > m_thr[c]) eip_n[c] = 1'b1;
            cc = ctx_reg(reg_addr, 4);
            w  = 0;
            if (reg_read && cc >= 0) w = winner(cc);
            pend_n = m_pend;
            infl_n = m_infl;
            for (int i = 1; i <= N_SRC; i++) begin
                if (i == w) begin
                    pend_n[i] = 1'b0;
                    infl_n[i] = 1'b1;
                end else if (irq_src[i] && !m_pend[i] && !m_infl[i]) begin
                    pend_n[i] = 1'b1;
                end
            end
            if (reg_write && cc >= 0 && reg_wdata >= 1 && reg_wdata <= N_SRC) begin
                id = int'(reg_wdata);
                if (m_en[cc][id] && id != w) infl_n[id] = 1'b0;
            end
            if (reg_write) begin
                k = prio_idx(reg_addr);
                if (k != 0) m_prio[k] = int'(reg_wdata & PRIO_MASK);
                k = en_ctx(reg_addr);
                if (k >= 0) m_en[k] = reg_wdata & SRC_MASK;
                k = ctx_reg(reg_addr, 0);
                if (k >= 0) m_thr[k] = int'(reg_wdata & PRIO_MASK);
            end
            m_pend = pend_n;
            m_infl = infl_n;
            m_eip  = eip_n;
        end
    endtask

    // Model advances on every rising edge from the inputs the DUT also sampled.
    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every falling edge: DUT read data and interrupt lines against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("model_rdata", reg_rdata, model_rdata(reg_addr));
            cmp("model_eip", 32'(eip), 32'(m_eip));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, vectors %0d", vectors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [25:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_read  = 1'b0;
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic cyc_chk(input logic [25:0] a, input logic rd, input logic [31:0] exp,
                           input int exp_eip, input string name);
        reg_addr  = a;
        reg_read  = rd;
        reg_write = 1'b0;
        @(negedge clk);
        cmp(name, reg_rdata, exp);
        if (exp_eip >= 0) cmp({name, "_eip"}, 32'(eip), 32'(exp_eip));
        tick();
        reg_read = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [25:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 6))
            0: a = 4 * $urandom_range(0, N_SRC + 2);
            1: a = 32'h1000;
            2: a = 32'h2000 + 32'h80 * $urandom_range(0, N_CTX);
            3: a = 32'h200000 + 32'h1000 * $urandom_range(0, N_CTX);
            4: a = 32'h200004 + 32'h1000 * $urandom_range(0, N_CTX);
            5: a = $urandom & 32'h03FF_FFFC;
            default: begin
                case ($urandom_range(0, 3))
                    0: a = 32'h1004;
                    1: a = 32'h2004;
                    2: a = 32'h200008;
                    default: a = 32'h2040;
                endcase
            end
        endcase
        return a[25:0];
    endfunction

    initial begin
        int op;
        int k;
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        rst         = 1'b1;
        reg_addr    = '0;
        reg_read    = 1'b0;
        reg_write   = 1'b0;
        reg_wdata   = '0;
        irq_src     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state of every mapped register, WARL and read-only behaviour
        for (int i = 1; i <= N_SRC; i++) cyc_chk(26'(4 * i), 1'b0, 32'h0, 0, "rst_prio");
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "rst_pend");
        for (int c = 0; c < N_CTX; c++) begin
            cyc_chk(26'(32'h2000 + 32'h80 * c), 1'b0, 32'h0, 0, "rst_en");
            cyc_chk(26'(32'h200000 + 32'h1000 * c), 1'b0, 32'h0, 0, "rst_thr");
            cyc_chk(26'(32'h200004 + 32'h1000 * c), 1'b1, 32'h0, 0, "rst_claim");
        end
        wr(26'h00C, 32'hFFFF_FFFF);
        cyc_chk(26'h00C, 1'b1, 32'h7, 0, "prio3_warl");
        wr(26'h1000, 32'hFFFF_FFFF);
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "pend_ro");
        wr(26'h000, 32'h5);
        cyc_chk(26'h000, 1'b0, 32'h0, 0, "prio0_zero");
        wr(26'h2000, 32'hFFFF_FFFF);
        cyc_chk(26'h2000, 1'b0, 32'hFFFF_FFFE, 0, "en_bit0");
        wr(26'h2000, 32'h0);
        wr(26'h00C, 32'h0);

        // Single source latency and claim
        wr(26'h014, 32'd2);
        wr(26'h2000, 32'h20);
        wr(26'h200000, 32'd1);
        irq_src[5] = 1'b1;
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "single_c0");
        cyc_chk(26'h1000, 1'b0, 32'h20, 0, "single_c1");
        cyc_chk(26'h1000, 1'b0, 32'h20, 1, "single_c2");
        cyc_chk(26'h200004, 1'b1, 32'd5, 1, "claim5");
        cyc_chk(26'h1000, 1'b0, 32'h0, 1, "claim5_k1");
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "claim5_k2");

        // Arbitration: priority first, lowest ID on ties
        wr(26'h008, 32'd3);
        wr(26'h010, 32'd5);
        wr(26'h018, 32'd5);
        wr(26'h2000, 32'h54);
        irq_src[2] = 1'b1;
        irq_src[4] = 1'b1;
        irq_src[6] = 1'b1;
        repeat (2) tick();
        cyc_chk(26'h200004, 1'b1, 32'd4, -1, "arb1");
        cyc_chk(26'h200004, 1'b1, 32'd6, -1, "arb2");
        cyc_chk(26'h200004, 1'b1, 32'd2, -1, "arb3");
        cyc_chk(26'h200004, 1'b1, 32'd0, -1, "arb4");

        // Threshold gates eip but not claim
        irq_src = '0;
        do_reset();
        wr(26'h004, 32'd2);
        wr(26'h200000, 32'd2);
        wr(26'h2000, 32'h2);
        irq_src[1] = 1'b1;
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "thr_c0");
        cyc_chk(26'h1000, 1'b0, 32'h2, 0, "thr_c1");
        cyc_chk(26'h1000, 1'b0, 32'h2, 0, "thr_c2");
        cyc_chk(26'h1000, 1'b0, 32'h2, 0, "thr_c3");
        cyc_chk(26'h200004, 1'b1, 32'd1, 0, "thr_claim1");
        wr(26'h020, 32'd2);
        wr(26'h2000, 32'h102);
        wr(26'h200000, 32'd1);
        irq_src[8] = 1'b1;
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "thr8_c0");
        cyc_chk(26'h1000, 1'b0, 32'h100, 0, "thr8_c1");
        cyc_chk(26'h1000, 1'b0, 32'h100, 1, "thr8_c2");

        // Completion rules with the source held high
        irq_src = '0;
        do_reset();
        wr(26'h01C, 32'd1);
        wr(26'h2000, 32'h80);
        irq_src[7] = 1'b1;
        repeat (2) tick();
        cyc_chk(26'h200004, 1'b1, 32'd7, -1, "cmp_claim7");
        wr(26'h201004, 32'd7);
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "ctx1_ign_a");
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "ctx1_ign_b");
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "ctx1_ign_c");
        wr(26'h200004, 32'd0);
        wr(26'h200004, 32'd40);
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "id0_40_a");
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "id0_40_b");
        wr(26'h200004, 32'd7);
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "cmp7_k1");
        cyc_chk(26'h1000, 1'b0, 32'h80, 0, "cmp7_k2");
        cyc_chk(26'h1000, 1'b0, 32'h80, 1, "cmp7_k3");

        // Reset in the same cycle as a claim while eip is high
        reg_addr = 26'h200004;
        reg_read = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        cmp("rstclaim_rdata", reg_rdata, 32'd7);
        cmp("rstclaim_eip", 32'(eip), 32'd1);
        tick();
        rst      = 1'b0;
        reg_read = 1'b0;
        cyc_chk(26'h1000, 1'b0, 32'h0, 0, "rst_act_pend");
        cyc_chk(26'h1000, 1'b0, 32'h80, 0, "rst_act_infl");
        cyc_chk(26'h01C, 1'b0, 32'h0, 0, "rst_act_prio7");
        cyc_chk(26'h2000, 1'b0, 32'h0, 0, "rst_act_en0");

        // Randomized traffic
        irq_src = '0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            op        = int'($urandom_range(0, 11));
            reg_read  = 1'b0;
            reg_write = 1'b0;
            rst       = 1'b0;
            reg_addr  = rand_addr();
            reg_wdata = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                k = int'($urandom_range(1, N_SRC));
                irq_src[k] = ~irq_src[k];
            end
            case (op)
                3, 4: reg_read = 1'b1;
                5, 6: begin
                    reg_addr = 26'(32'h200004 + 32'h1000 * $urandom_range(0, N_CTX - 1));
                    reg_read = 1'b1;
                end
                7: reg_write = 1'b1;
                8: begin
                    reg_addr  = 26'(32'h200004 + 32'h1000 * $urandom_range(0, N_CTX - 1));
                    reg_wdata = $urandom_range(0, N_SRC + 3);
                    reg_write = 1'b1;
                end
                9: begin
                    reg_addr  = 26'(4 * $urandom_range(1, N_SRC));
                    reg_wdata = $urandom_range(0, 7);
                    reg_write = 1'b1;
                end
                10: begin
                    reg_addr  = 26'(32'h2000 + 32'h80 * $urandom_range(0, N_CTX - 1));
                    reg_write = 1'b1;
                end
                11: begin
                    reg_addr  = 26'(32'h200000 + 32'h1000 * $urandom_range(0, N_CTX - 1));
                    reg_wdata = $urandom_range(0, 7);
                    reg_write = 1'b1;
                end
                default: ;
            endcase
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            tick();
        end
        reg_read  = 1'b0;
        reg_write = 1'b0;
        rst       = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
